// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide/modulo unit for the execute stage.
// Processes one bit per clock: shift-add multiply, restoring divide.
module mdu_iter #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_MOD = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [WIDTH-1:0]   result_hi_reg;
  logic               div_zero_reg;

  logic               op_valid;
  logic               accept;
  logic               zero_div;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign op_valid  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign accept    = (state_reg == S_IDLE) && start && op_valid;
  assign zero_div  = (op != OP_MUL) && (b == '0);
  assign last_iter = (state_reg == S_RUN) && (cnt_reg == CW'(WIDTH - 1));

  // Multiply: high half accumulates the multiplicand, whole product shifts right.
  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                   + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign prod_next = {mul_sum, prod_reg[WIDTH-1:1]};

  // Divide: the remainder is always below the divisor, so a borrow out of
  // bit WIDTH of the trial subtract means "does not fit".
  assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, divisor_reg};
  assign div_ge    = ~div_trial[WIDTH];
  assign rem_next  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo_reg[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = zero_div ? S_DONE : S_RUN;
      S_RUN:  if (last_iter) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != S_IDLE);
    done = (state_reg == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= '0;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      prod_reg      <= '0;
      divisor_reg   <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      div_zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg       <= op;
            cnt_reg      <= '0;
            mcand_reg    <= a;
            prod_reg     <= {{WIDTH{1'b0}}, b};
            divisor_reg  <= b;
            quo_reg      <= a;
            rem_reg      <= '0;
            div_zero_reg <= zero_div;
            if (zero_div) begin
              result_reg    <= (op == OP_DIV) ? {WIDTH{1'b1}} : a;
              result_hi_reg <= '0;
            end
          end
        end
        S_RUN: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (op_reg == OP_MUL) begin
            prod_reg <= prod_next;
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
          end
          if (last_iter) begin
            case (op_reg)
              OP_MUL: begin
                result_reg    <= prod_next[WIDTH-1:0];
                result_hi_reg <= prod_next[2*WIDTH-1:WIDTH];
              end
              OP_DIV: begin
                result_reg    <= quo_next;
                result_hi_reg <= '0;
              end
              default: begin
                result_reg    <= rem_next;
                result_hi_reg <= '0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mdu_iter;

  localparam int W = 16;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_MOD = 4'b1010;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] result, result_hi;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t last_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  mdu_iter #(.WIDTH(W), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(result), 64'(mon_e.res));
        check("result_hi", 64'(result_hi), 64'(mon_e.hi));
        check("div_zero", 64'(div_zero), 64'(mon_e.dz));
        check("done_cycle", 64'(cyc), 64'(mon_e.due));
        last_e = mon_e;
        $display("op done: result=%0h hi=%0h dz=%0b cycle=%0d", result, result_hi, div_zero, cyc);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    int          t;
    logic [31:0] p;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_wait_timeout", 64'(busy), 64'(0));
    p = 32'(x) * 32'(y);
    e.dz = (o != OP_MUL) && (y == 0);
    if (o == OP_MUL) begin
      e.res = p[W-1:0];
      e.hi  = p[2*W-1:W];
    end else begin
      e.hi = '0;
      if (y == 0) e.res = (o == OP_DIV) ? {W{1'b1}} : x;
      else        e.res = (o == OP_DIV) ? x / y : x % y;
    end
    e.due = cyc + 1 + (e.dz ? 0 : W);
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] rx, ry;
    last_e.res = '0; last_e.hi = '0; last_e.dz = 1'b0; last_e.due = 0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_result_hi", 64'(result_hi), 64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    issue(OP_MUL, 16'd1000, 16'd1000);
    drain();
    issue(OP_DIV, 16'd1000, 16'd7);
    issue(OP_MOD, 16'd1000, 16'd7);
    issue(OP_MOD, 16'hFFFF, 16'h0010);
    drain();

    issue(OP_DIV, 16'd1234, 16'd0);
    issue(OP_MOD, 16'd1234, 16'd0);
    issue(OP_DIV, 16'd50, 16'd5);
    drain();

    // Start while busy must be ignored and produce no extra done.
    issue(OP_MUL, 16'd3, 16'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 16'd9; b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    check("busy_ignore_result", 64'(result), 64'(15));

    // Reset mid-operation abandons the op.
    issue(OP_DIV, 16'hFFFF, 16'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_result_hi", 64'(result_hi), 64'(0));
    last_e.res = '0; last_e.hi = '0; last_e.dz = 1'b0;
    repeat (20) @(negedge clk);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF);
    drain();

    // Invalid opcode: stays idle, outputs hold the last result.
    start = 1'b1; op = 4'b0011; a = 16'd1; b = 16'd2;
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("badop_busy2", 64'(busy), 64'(0));
    check("badop_result", 64'(result), 64'(last_e.res));
    check("badop_result_hi", 64'(result_hi), 64'(last_e.hi));
    check("badop_div_zero", 64'(div_zero), 64'(last_e.dz));

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 2))
        0:       ro = OP_MUL;
        1:       ro = OP_DIV;
        default: ro = OP_MOD;
      endcase
      rx = W'($urandom);
      ry = W'($urandom);
      if (i % 8 == 0) ry = W'($urandom_range(1, 15));
      if (ro != OP_MUL && ry == 0) ry = 16'd1;
      issue(ro, rx, ry);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative unsigned multiply/divide unit in the execute stage; handles the ALU opcodes MUL (4'b1000), DIV (4'b1001) and MOD (4'b1010) that the hazard/stall control unit stalls the pipeline for.
- Consumes the execute-stage opcode and operands, runs one bit per clock, and signals completion.
- The control unit uses `busy`/`done` to release `en0`/`en1`.

Parameters:
- `WIDTH`, 16, operand and result width in bits (4..32).
- `CW`, 5, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  4  ALU opcode: 4'b1000 MUL, 4'b1001 DIV, 4'b1010 MOD; any other value means no operation.
- `a`  in  WIDTH  multiplicand / dividend; captured with `start`.
- `b`  in  WIDTH  multiplier / divisor; captured with `start`.
- `busy`  out  1  high in RUN and DONE states.
- `done`  out  1  one-cycle pulse; result outputs valid in this cycle.
- `result`  out  WIDTH  MUL: low product half; DIV: quotient; MOD: remainder.
- `result_hi`  out  WIDTH  MUL: high product half; DIV/MOD: 0.
- `div_zero`  out  1  set when the last DIV/MOD had `b`==0; held until the next accepted start.

Behaviour:
- Clock is `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - state=IDLE, `busy`=0, `done`=0, `result`=0, `result_hi`=0, `div_zero`=0, counter=0.
  - `rst` wins over every other input, including mid-operation; the operation is abandoned and no `done` is issued.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with `start`=1 and a valid `op`: capture `op`, `a`, `b`; clear `div_zero`; counter=0.
  - If DIV/MOD with `b`==0: go straight to DONE.
  - Otherwise go to RUN.
  - `start`=1 with an invalid `op`: ignored, stay IDLE.
- RUN: one iteration per edge, counter += 1. After the WIDTH-th iteration (counter==WIDTH-1 at that edge) go to DONE.
- DONE:
  - `done`=1 for exactly one cycle; all result outputs valid.
  - Next edge returns to IDLE unconditionally.
  - `start` is not sampled in DONE.
- MUL algorithm:
  - 2*WIDTH accumulator, shift-add, LSB-first on the multiplier.
  - Product = a*b unsigned, exact, no overflow.
  - `result` = P[WIDTH-1:0], `result_hi` = P[2*WIDTH-1:WIDTH].
- DIV/MOD algorithm:
  - Restoring division, MSB-first.
  - Partial remainder is WIDTH+1 bits so the trial subtract never wraps.
  - DIV → `result` = floor(a/b). MOD → `result` = a mod b. `result_hi`=0.
- Divide by zero:
  - DIV: `result` = all ones. MOD: `result` = a.
  - `result_hi`=0, `div_zero`=1.
  - Latency 1: `done` asserts in the cycle after the accepting edge.
- Latency:
  - Normal ops: `done` is high in the cycle following the (WIDTH+1)-th rising edge counted from the accepting edge, inclusive of that edge.
  - i.e. for WIDTH=16, `done` is seen 17 cycles after `start` is accepted.
  - Latency is fixed and independent of operand values.
- Result holding:
  - `result`, `result_hi` and `div_zero` keep their value after DONE until the next accepted start.
  - They are updated only on the edge entering DONE.
- Busy handling:
  - `start` while `busy`=1 is ignored; inputs are not recaptured.
  - Operands changing after acceptance have no effect.
- Back-to-back: `start` held high through DONE is accepted on the first IDLE edge, so there is 1 idle cycle between operations.
- Internal work registers are not visible on the outputs during RUN.

Test Plan:
- Reset, then MUL: `a`=1000, `b`=1000 → `done` once, 17 cycles after accept; `result`=0x4240, `result_hi`=0x000F, `div_zero`=0.
- DIV 1000/7 → `result`=142; MOD 1000%7 → `result`=6; MOD 0xFFFF%0x0010 → `result`=0x000F; `result_hi`=0 in all cases.
- DIV 1234/0 → `done` in the cycle after accept, `result`=0xFFFF, `div_zero`=1. MOD 1234/0 → `result`=1234, `div_zero`=1. The next valid op clears `div_zero`.
- Start MUL 3*5; pulse `start` with DIV 9/3 on cycle 5 → ignored; `done` at cycle 17 with `result`=15; no second `done`.
- Start DIV 0xFFFF/1 and assert `rst` on cycle 8 → outputs 0, IDLE, no `done`. A fresh MUL 0xFFFF*0xFFFF then gives `result`=0x0001, `result_hi`=0xFFFE.
- `start`=1 with `op`=4'b0011 → stays IDLE, `busy`=0, outputs unchanged. Random unsigned operands (1000 vectors) checked against a reference model, `b`≠0 for DIV/MOD.
